// File: rtl/zap_page_walker_pkg.sv
// Shared definitions for the page-table walker: descriptor encodings, FSR codes,
// TLB entry widths. Entries are packed {TAG, BASE, DAC_SEL, AP, CB}, MSB first.
package zap_page_walker_pkg;

    localparam logic [1:0] L1_FAULT   = 2'b00;
    localparam logic [1:0] L1_COARSE  = 2'b01;
    localparam logic [1:0] L1_SECTION = 2'b10;
    localparam logic [1:0] L1_FINE    = 2'b11;

    localparam logic [1:0] L2_FAULT   = 2'b00;
    localparam logic [1:0] L2_LARGE   = 2'b01;
    localparam logic [1:0] L2_SMALL   = 2'b10;
    localparam logic [1:0] L2_TINY    = 2'b11;

    localparam logic [3:0] FSR_SECTION_TRANSLATION_FAULT = 4'h5;
    localparam logic [3:0] FSR_PAGE_TRANSLATION_FAULT    = 4'h7;

    typedef logic [3:0] domain_t;

    // Tag = VA bits above the index, so widths shrink as the TLB grows.
    function automatic int section_wdt(int n);
        return (12 - $clog2(n)) + 12 + 4 + 2 + 2;
    endfunction

    function automatic int lpage_wdt(int n);
        return (16 - $clog2(n)) + 16 + 4 + 8 + 2;
    endfunction

    function automatic int spage_wdt(int n);
        return (20 - $clog2(n)) + 20 + 4 + 8 + 2;
    endfunction

    function automatic logic [7:0] fsr_pack(domain_t dom, logic [3:0] status);
        return {dom, status};
    endfunction

endpackage

// File: rtl/zap_page_walker_if.sv
// Wishbone-style read-only bus between the page walker and the memory arbiter.
interface zap_page_walker_if;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [31:0] o_wb_adr;
    logic        i_wb_ack;
    logic [31:0] i_wb_dat;

    modport master (output o_wb_cyc, o_wb_stb, o_wb_adr, input i_wb_ack, i_wb_dat);
    modport slave  (input o_wb_cyc, o_wb_stb, o_wb_adr, output i_wb_ack, i_wb_dat);
endinterface

// File: rtl/zap_page_walker.sv
// Hardware page-table walker: fetches L1 and, for coarse tables, L2 descriptors,
// then writes one section/large/small TLB entry or raises a translation fault.
//
// state      | meaning
// IDLE       | waiting for i_walk
// L1_FETCH   | bus read of the level-1 descriptor
// L2_FETCH   | one-cycle bus gap, then read of the level-2 descriptor
// REFRESH    | TLB write cycle plus one settle cycle before re-sampling i_walk
module zap_page_walker
    import zap_page_walker_pkg::*;
#(
    parameter int LPAGE_TLB_ENTRIES   = 8,
    parameter int SPAGE_TLB_ENTRIES   = 8,
    parameter int SECTION_TLB_ENTRIES = 8
) (
    input  logic                                            i_clk,
    input  logic                                            i_reset_n,
    input  logic                                            i_walk,
    input  logic [31:0]                                     i_va,
    input  logic [17:0]                                     i_baddr,
    output logic                                            o_busy,
    zap_page_walker_if.master                               wb,
    output logic                                            o_setlb_wen,
    output logic                                            o_lptlb_wen,
    output logic                                            o_sptlb_wen,
    output logic [section_wdt(SECTION_TLB_ENTRIES)-1:0]     o_setlb_wdata,
    output logic [lpage_wdt(LPAGE_TLB_ENTRIES)-1:0]         o_lptlb_wdata,
    output logic [spage_wdt(SPAGE_TLB_ENTRIES)-1:0]         o_sptlb_wdata,
    output logic [$clog2(SECTION_TLB_ENTRIES)-1:0]          o_setlb_waddr,
    output logic [$clog2(LPAGE_TLB_ENTRIES)-1:0]            o_lptlb_waddr,
    output logic [$clog2(SPAGE_TLB_ENTRIES)-1:0]            o_sptlb_waddr,
    output logic                                            o_fault,
    output logic [7:0]                                      o_fsr,
    output logic [31:0]                                     o_far
);

    localparam int SE_IDX = $clog2(SECTION_TLB_ENTRIES);
    localparam int LP_IDX = $clog2(LPAGE_TLB_ENTRIES);
    localparam int SP_IDX = $clog2(SPAGE_TLB_ENTRIES);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_L1_FETCH = 2'd1;
    localparam logic [1:0] S_L2_FETCH = 2'd2;
    localparam logic [1:0] S_REFRESH  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_va;
    domain_t     r_dom;
    logic        r_cyc;
    logic [31:0] r_adr;
    logic        r_busy;
    logic        r_refresh_cnt;

    logic [31:0] w_desc;
    logic        w_ack;
    logic        w_unused_ok;

    assign w_desc      = wb.i_wb_dat;
    assign w_ack       = r_cyc & wb.i_wb_ack;
    assign w_unused_ok = w_desc[9];

    assign wb.o_wb_cyc = r_cyc;
    assign wb.o_wb_stb = r_cyc;
    assign wb.o_wb_adr = r_adr;
    assign o_busy      = r_busy;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_va          <= '0;
            r_dom         <= '0;
            r_cyc         <= 1'b0;
            r_adr         <= '0;
            r_busy        <= 1'b0;
            r_refresh_cnt <= 1'b0;
            o_setlb_wen   <= 1'b0;
            o_lptlb_wen   <= 1'b0;
            o_sptlb_wen   <= 1'b0;
            o_setlb_wdata <= '0;
            o_lptlb_wdata <= '0;
            o_sptlb_wdata <= '0;
            o_setlb_waddr <= '0;
            o_lptlb_waddr <= '0;
            o_sptlb_waddr <= '0;
            o_fault       <= 1'b0;
            o_fsr         <= '0;
            o_far         <= '0;
        end else begin
            o_setlb_wen <= 1'b0;
            o_lptlb_wen <= 1'b0;
            o_sptlb_wen <= 1'b0;
            o_fault     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_walk) begin
                        r_va    <= i_va;
                        r_adr   <= {i_baddr, i_va[31:20], 2'b00};
                        r_cyc   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_L1_FETCH;
                    end
                end

                S_L1_FETCH: begin
                    if (w_ack) begin
                        r_cyc         <= 1'b0;
                        r_refresh_cnt <= 1'b1;
                        case (w_desc[1:0])
                            L1_SECTION: begin
                                o_setlb_wen   <= 1'b1;
                                o_setlb_wdata <= {r_va[31:20+SE_IDX], w_desc[31:20],
                                                  w_desc[8:5], w_desc[11:10], w_desc[3:2]};
                                o_setlb_waddr <= r_va[20 +: SE_IDX];
                                r_state       <= S_REFRESH;
                            end
                            L1_COARSE: begin
                                r_dom   <= w_desc[8:5];
                                r_adr   <= {w_desc[31:10], r_va[19:12], 2'b00};
                                r_state <= S_L2_FETCH;
                            end
                            default: begin
                                o_fault <= 1'b1;
                                o_fsr   <= fsr_pack(w_desc[8:5], FSR_SECTION_TRANSLATION_FAULT);
                                o_far   <= r_va;
                                r_state <= S_REFRESH;
                            end
                        endcase
                    end
                end

                // Entered with cyc low, giving the one-cycle bus gap between reads.
                S_L2_FETCH: begin
                    if (!r_cyc) begin
                        r_cyc <= 1'b1;
                    end else if (w_ack) begin
                        r_cyc         <= 1'b0;
                        r_refresh_cnt <= 1'b1;
                        r_state       <= S_REFRESH;
                        case (w_desc[1:0])
                            L2_LARGE: begin
                                o_lptlb_wen   <= 1'b1;
                                o_lptlb_wdata <= {r_va[31:16+LP_IDX], w_desc[31:16],
                                                  r_dom, w_desc[11:4], w_desc[3:2]};
                                o_lptlb_waddr <= r_va[16 +: LP_IDX];
                            end
                            L2_SMALL: begin
                                o_sptlb_wen   <= 1'b1;
                                o_sptlb_wdata <= {r_va[31:12+SP_IDX], w_desc[31:12],
                                                  r_dom, w_desc[11:4], w_desc[3:2]};
                                o_sptlb_waddr <= r_va[12 +: SP_IDX];
                            end
                            default: begin
                                o_fault <= 1'b1;
                                o_fsr   <= fsr_pack(r_dom, FSR_PAGE_TRANSLATION_FAULT);
                                o_far   <= r_va;
                            end
                        endcase
                    end
                end

                // First cycle carries the write strobe, second lets TLB readback settle.
                S_REFRESH: begin
                    if (r_refresh_cnt == 1'b0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_refresh_cnt <= r_refresh_cnt - 1'b1;
                    end
                end

                default: begin
                    r_cyc   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
